// File: rtl/mem_pkg.sv
// Shared types and default sizing for the memory stage and its store buffer.
package mem_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 17;
  localparam int DEF_SB_DEPTH = 4;
  localparam int DEF_RD_W     = 5;

  // dmem port controller states
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_WAIT  = 2'd1,
    STORE_WAIT = 2'd2
  } mem_state_e;

endpackage

// File: rtl/sb_fifo.sv
// Circular posted-store buffer. Entries are pushed at the tail and popped
// from the head. The head stays searchable until it is popped. A parallel
// search returns the data of the youngest entry whose address matches.
module sb_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 17,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic [ADDR_W-1:0] search_addr,
  output logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] srch_idx;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH (power of 2).
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
  end

  // Pointer/count registers, cleared by reset (buffered stores are dropped).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents beyond count are never looked at, so no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem[tail_q] <= push_addr;
      data_mem[tail_q] <= push_data;
    end
  end

  // Walk from oldest to youngest so the last match (youngest) wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    srch_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      srch_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_mem[srch_idx] == search_addr)) begin
        hit      = 1'b1;
        hit_data = data_mem[srch_idx];
      end
    end
  end

  assign count     = count_q;
  assign head_addr = addr_mem[head_q];
  assign head_data = data_mem[head_q];

endmodule

// File: rtl/mem_stage_sb.sv
// Memory stage: owns the dmem req/ack port, a posted store buffer with
// load forwarding, the stall output and the M/W pipeline latch.
//
// dmem handshake: req_dmem rises with wren/address_dmem/data and all four
// hold steady until the cycle ack_dmem is seen high; the request drops on
// the following edge. ack_dmem outside an outstanding request is ignored.
module mem_stage_sb
  import mem_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int SB_DEPTH = DEF_SB_DEPTH,
  parameter int RD_W     = DEF_RD_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_xm,
  input  logic              is_lw_xm,
  input  logic              is_sw_xm,
  input  logic              exception_xm,
  input  logic [DATA_W-1:0] exec_out_xm,
  input  logic [DATA_W-1:0] rd_out1_xm,
  input  logic [RD_W-1:0]   rd_xm,
  output logic              stall_m,
  output logic              req_dmem,
  output logic              wren,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  input  logic              ack_dmem,
  input  logic [DATA_W-1:0] q_dmem,
  output logic              valid_mw,
  output logic              is_lw_mw,
  output logic              exception_mw,
  output logic [DATA_W-1:0] exec_out_mw,
  output logic [DATA_W-1:0] mem_out_mw,
  output logic [RD_W-1:0]   rd_mw,
  output logic              sb_empty,
  output mem_state_e        state_dbg
);

  localparam int CNT_W = $clog2(SB_DEPTH) + 1;

  logic              mem_access, is_load, is_store;
  logic              load_miss, load_done, store_done, sb_full, stall;
  logic [ADDR_W-1:0] xm_addr;
  logic [CNT_W-1:0]  sb_count;
  logic [ADDR_W-1:0] sb_head_addr;
  logic [DATA_W-1:0] sb_head_data;
  logic              sb_hit;
  logic [DATA_W-1:0] sb_hit_data;

  mem_state_e        state_q, state_d;
  logic              req_q, req_d, wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              valid_mw_q, valid_mw_d, is_lw_mw_q, is_lw_mw_d;
  logic              exc_mw_q, exc_mw_d;
  logic [DATA_W-1:0] exec_mw_q, exec_mw_d, mem_mw_q, mem_mw_d;
  logic [RD_W-1:0]   rd_mw_q, rd_mw_d;

  // Instruction decode and stall: excepting instructions never touch memory.
  always_comb begin
    mem_access = valid_xm & ~exception_xm;
    is_load    = mem_access & is_lw_xm;
    is_store   = mem_access & is_sw_xm & ~is_lw_xm;
    xm_addr    = exec_out_xm[ADDR_W-1:0];
    load_miss  = is_load & ~sb_hit;
    load_done  = (state_q == LOAD_WAIT) & ack_dmem;
    store_done = (state_q == STORE_WAIT) & ack_dmem;
    sb_full    = (sb_count == CNT_W'(SB_DEPTH));
    // A store acked this cycle frees a slot the waiting store may use now.
    stall      = (load_miss & ~load_done) | (is_store & sb_full & ~store_done);
  end

  sb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (SB_DEPTH)
  ) u_sb (
    .clock       (clock),
    .reset       (reset),
    .push        (is_store & ~stall),
    .push_addr   (xm_addr),
    .push_data   (rd_out1_xm),
    .pop         (store_done),
    .search_addr (xm_addr),
    .count       (sb_count),
    .head_addr   (sb_head_addr),
    .head_data   (sb_head_data),
    .hit         (sb_hit),
    .hit_data    (sb_hit_data)
  );

  // Next-state and dmem port values; a load miss beats draining the buffer.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wren_d  = wren_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (load_miss) begin
          state_d = LOAD_WAIT;
          req_d   = 1'b1;
          wren_d  = 1'b0;
          addr_d  = xm_addr;
        end else if (sb_count != '0) begin
          state_d = STORE_WAIT;
          req_d   = 1'b1;
          wren_d  = 1'b1;
          addr_d  = sb_head_addr;
          data_d  = sb_head_data;
        end
      end
      LOAD_WAIT, STORE_WAIT: begin
        if (ack_dmem) begin
          state_d = IDLE;
          req_d   = 1'b0;
          wren_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        wren_d  = 1'b0;
      end
    endcase
  end

  // FSM state and registered dmem port; reset abandons any request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // M/W contents: a bubble while stalled, otherwise X/M plus load data.
  always_comb begin
    valid_mw_d = 1'b0;
    is_lw_mw_d = 1'b0;
    exc_mw_d   = 1'b0;
    exec_mw_d  = '0;
    mem_mw_d   = '0;
    rd_mw_d    = '0;
    if (!stall) begin
      valid_mw_d = valid_xm;
      is_lw_mw_d = is_lw_xm;
      exc_mw_d   = exception_xm;
      exec_mw_d  = exec_out_xm;
      rd_mw_d    = rd_xm;
      if (load_done)             mem_mw_d = q_dmem;
      else if (is_load & sb_hit) mem_mw_d = sb_hit_data;
    end
  end

  // M/W latch registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_mw_q <= 1'b0;
      is_lw_mw_q <= 1'b0;
      exc_mw_q   <= 1'b0;
      exec_mw_q  <= '0;
      mem_mw_q   <= '0;
      rd_mw_q    <= '0;
    end else begin
      valid_mw_q <= valid_mw_d;
      is_lw_mw_q <= is_lw_mw_d;
      exc_mw_q   <= exc_mw_d;
      exec_mw_q  <= exec_mw_d;
      mem_mw_q   <= mem_mw_d;
      rd_mw_q    <= rd_mw_d;
    end
  end

  assign stall_m      = stall;
  assign req_dmem     = req_q;
  assign wren         = wren_q;
  assign address_dmem = addr_q;
  assign data         = data_q;
  assign valid_mw     = valid_mw_q;
  assign is_lw_mw     = is_lw_mw_q;
  assign exception_mw = exc_mw_q;
  assign exec_out_mw  = exec_mw_q;
  assign mem_out_mw   = mem_mw_q;
  assign rd_mw        = rd_mw_q;
  assign sb_empty     = (sb_count == '0);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_mem_stage_sb.sv
// Directed bench for mem_stage_sb: load miss, forwarding, full buffer,
// load behind a pending store, exception pass-through and async reset.
module tb_mem_stage_sb;
  import mem_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 17;
  localparam int RD_W   = 5;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              valid_xm = 1'b0, is_lw_xm = 1'b0, is_sw_xm = 1'b0, exception_xm = 1'b0;
  logic [DATA_W-1:0] exec_out_xm = '0, rd_out1_xm = '0;
  logic [RD_W-1:0]   rd_xm = '0;
  logic              stall_m, req_dmem, wren;
  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] data;
  logic              ack_dmem = 1'b0;
  logic [DATA_W-1:0] q_dmem = '0;
  logic              valid_mw, is_lw_mw, exception_mw;
  logic [DATA_W-1:0] exec_out_mw, mem_out_mw;
  logic [RD_W-1:0]   rd_mw;
  logic              sb_empty;
  mem_state_e        state_dbg;

  int tests_run = 0;
  int tests_failed = 0;
  int stall_cycles = 0;
  int rd_req_cycles = 0;
  int snap_stall, snap_rd;

  mem_stage_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SB_DEPTH(4), .RD_W(RD_W)) dut (
    .clock(clock), .reset(reset), .valid_xm(valid_xm), .is_lw_xm(is_lw_xm),
    .is_sw_xm(is_sw_xm), .exception_xm(exception_xm), .exec_out_xm(exec_out_xm),
    .rd_out1_xm(rd_out1_xm), .rd_xm(rd_xm), .stall_m(stall_m), .req_dmem(req_dmem),
    .wren(wren), .address_dmem(address_dmem), .data(data), .ack_dmem(ack_dmem),
    .q_dmem(q_dmem), .valid_mw(valid_mw), .is_lw_mw(is_lw_mw),
    .exception_mw(exception_mw), .exec_out_mw(exec_out_mw), .mem_out_mw(mem_out_mw),
    .rd_mw(rd_mw), .sb_empty(sb_empty), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  // Cycle counters sampled mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (!reset && stall_m) stall_cycles++;
    if (!reset && req_dmem && !wren) rd_req_cycles++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: act=0x%08h exp=0x%08h", tag, act, exp);
    end
  endtask

  // Advance one cycle; inputs change and checks happen 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    valid_xm = 1'b0; is_lw_xm = 1'b0; is_sw_xm = 1'b0; exception_xm = 1'b0;
  endtask

  task automatic drive_sw(input logic [31:0] addr, input logic [31:0] wdata);
    valid_xm = 1'b1; is_lw_xm = 1'b0; is_sw_xm = 1'b1; exception_xm = 1'b0;
    exec_out_xm = addr; rd_out1_xm = wdata; rd_xm = 5'd0;
    #1;
  endtask

  task automatic drive_lw(input logic [31:0] addr, input logic [4:0] rd, input logic exc);
    valid_xm = 1'b1; is_lw_xm = 1'b1; is_sw_xm = 1'b0; exception_xm = exc;
    exec_out_xm = addr; rd_xm = rd;
    #1;
  endtask

  // Wait (bounded) for a store request, check it, then ack it for one cycle.
  task automatic drain_expect(input string tag, input logic [31:0] addr, input logic [31:0] wdata);
    int n = 0;
    while (!req_dmem && n < 20) begin step(); n++; end
    check_eq({tag, "_req"}, 32'(req_dmem), 32'd1);
    check_eq({tag, "_wren"}, 32'(wren), 32'd1);
    check_eq({tag, "_addr"}, 32'(address_dmem), addr);
    check_eq({tag, "_data"}, data, wdata);
    ack_dmem = 1'b1;
    step();
    ack_dmem = 1'b0;
  endtask

  initial begin
    // ---------------- reset state ----------------
    #12;
    check_eq("rst_req", 32'(req_dmem), 32'd0);
    check_eq("rst_wren", 32'(wren), 32'd0);
    check_eq("rst_addr", 32'(address_dmem), 32'd0);
    check_eq("rst_data", data, 32'd0);
    check_eq("rst_empty", 32'(sb_empty), 32'd1);
    check_eq("rst_valid_mw", 32'(valid_mw), 32'd0);
    check_eq("rst_mem_out", mem_out_mw, 32'd0);
    check_eq("rst_state", 32'(state_dbg), 32'(IDLE));
    reset = 1'b0;
    step();

    // ---------------- load miss, ack on 3rd request cycle ----------------
    snap_stall = stall_cycles; snap_rd = rd_req_cycles;
    drive_lw(32'h10, 5'd7, 1'b0);
    check_eq("lm_stall_t0", 32'(stall_m), 32'd1);
    step();
    check_eq("lm_req", 32'(req_dmem), 32'd1);
    check_eq("lm_wren", 32'(wren), 32'd0);
    check_eq("lm_addr", 32'(address_dmem), 32'h10);
    step();
    check_eq("lm_stall_t2", 32'(stall_m), 32'd1);
    step();
    ack_dmem = 1'b1; q_dmem = 32'hDEADBEEF; #1;
    check_eq("lm_stall_ack", 32'(stall_m), 32'd0);
    step();
    ack_dmem = 1'b0; drive_idle();
    check_eq("lm_valid_mw", 32'(valid_mw), 32'd1);
    check_eq("lm_is_lw_mw", 32'(is_lw_mw), 32'd1);
    check_eq("lm_rd_mw", 32'(rd_mw), 32'd7);
    check_eq("lm_mem_out", mem_out_mw, 32'hDEADBEEF);
    check_eq("lm_req_drop", 32'(req_dmem), 32'd0);
    check_eq("lm_stall_cnt", 32'(stall_cycles - snap_stall), 32'd3);
    check_eq("lm_req_cnt", 32'(rd_req_cycles - snap_rd), 32'd3);
    step();
    check_eq("lm_bubble", 32'(valid_mw), 32'd0);

    // ---------------- two stores same address, forwarded load ----------------
    snap_stall = stall_cycles; snap_rd = rd_req_cycles;
    drive_sw(32'h20, 32'h11111111);
    check_eq("fw_sw1_stall", 32'(stall_m), 32'd0);
    step();
    drive_sw(32'h20, 32'h22222222);
    step();
    check_eq("fw_st_issue_wren", 32'(wren), 32'd1);
    check_eq("fw_st_issue_data", data, 32'h11111111);
    drive_lw(32'h20, 5'd3, 1'b0);
    check_eq("fw_lw_stall", 32'(stall_m), 32'd0);
    step();
    drive_idle();
    check_eq("fw_valid_mw", 32'(valid_mw), 32'd1);
    check_eq("fw_mem_out", mem_out_mw, 32'h22222222);
    check_eq("fw_stall_cnt", 32'(stall_cycles - snap_stall), 32'd0);
    check_eq("fw_rdreq_cnt", 32'(rd_req_cycles - snap_rd), 32'd0);
    drain_expect("fw_d0", 32'h20, 32'h11111111);
    drain_expect("fw_d1", 32'h20, 32'h22222222);
    check_eq("fw_empty", 32'(sb_empty), 32'd1);

    // ---------------- fill buffer, fifth store stalls until ack ----------------
    for (int i = 0; i < 4; i++) begin
      drive_sw(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
      check_eq("full_fill_stall", 32'(stall_m), 32'd0);
      step();
    end
    drive_sw(32'h110, 32'hA4);
    check_eq("full_stall0", 32'(stall_m), 32'd1);
    step();
    check_eq("full_stall1", 32'(stall_m), 32'd1);
    check_eq("full_head_addr", 32'(address_dmem), 32'h100);
    step();
    ack_dmem = 1'b1; #1;
    check_eq("full_stall_ack", 32'(stall_m), 32'd0);
    step();
    ack_dmem = 1'b0;
    drive_sw(32'h114, 32'hA5);
    check_eq("full_still4", 32'(stall_m), 32'd1);
    check_eq("full_not_empty", 32'(sb_empty), 32'd0);
    drive_idle();
    drain_expect("full_d1", 32'h104, 32'hA1);
    drain_expect("full_d2", 32'h108, 32'hA2);
    drain_expect("full_d3", 32'h10C, 32'hA3);
    drain_expect("full_d4", 32'h110, 32'hA4);
    check_eq("full_empty", 32'(sb_empty), 32'd1);
    step();
    check_eq("full_idle_req", 32'(req_dmem), 32'd0);

    // ---------------- load miss behind a pending store ----------------
    drive_sw(32'h40, 32'h55);
    step();
    drive_idle();
    step();
    check_eq("lbs_store_req", 32'(req_dmem & wren), 32'd1);
    drive_lw(32'h80, 5'd9, 1'b0);
    check_eq("lbs_stall0", 32'(stall_m), 32'd1);
    step();
    ack_dmem = 1'b1; #1;
    check_eq("lbs_stall_stack", 32'(stall_m), 32'd1);
    step();
    ack_dmem = 1'b0;
    check_eq("lbs_req_low", 32'(req_dmem), 32'd0);
    check_eq("lbs_state_idle", 32'(state_dbg), 32'(IDLE));
    check_eq("lbs_stall2", 32'(stall_m), 32'd1);
    step();
    check_eq("lbs_rd_req", 32'(req_dmem), 32'd1);
    check_eq("lbs_rd_wren", 32'(wren), 32'd0);
    check_eq("lbs_rd_addr", 32'(address_dmem), 32'h80);
    ack_dmem = 1'b1; q_dmem = 32'hCAFEF00D; #1;
    check_eq("lbs_stall_ld_ack", 32'(stall_m), 32'd0);
    step();
    ack_dmem = 1'b0; drive_idle();
    check_eq("lbs_mem_out", mem_out_mw, 32'hCAFEF00D);
    check_eq("lbs_rd_mw", 32'(rd_mw), 32'd9);

    // ---------------- excepting load ----------------
    drive_lw(32'h300, 5'd2, 1'b1);
    check_eq("exc_stall", 32'(stall_m), 32'd0);
    step();
    drive_idle();
    check_eq("exc_req", 32'(req_dmem), 32'd0);
    check_eq("exc_valid_mw", 32'(valid_mw), 32'd1);
    check_eq("exc_exc_mw", 32'(exception_mw), 32'd1);
    check_eq("exc_exec_mw", exec_out_mw, 32'h300);
    step();

    // ---------------- async reset during LOAD_WAIT with 2 stores ----------------
    drive_sw(32'h500, 32'h1);
    step();
    drive_sw(32'h504, 32'h2);
    step();
    drive_sw(32'h508, 32'h3);
    step();
    drive_lw(32'h600, 5'd4, 1'b0);
    ack_dmem = 1'b1; #1;
    step();
    ack_dmem = 1'b0;
    step();
    check_eq("ar_state_lw", 32'(state_dbg), 32'(LOAD_WAIT));
    check_eq("ar_req_pre", 32'(req_dmem), 32'd1);
    check_eq("ar_empty_pre", 32'(sb_empty), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check_eq("ar_req", 32'(req_dmem), 32'd0);
    check_eq("ar_wren", 32'(wren), 32'd0);
    check_eq("ar_empty", 32'(sb_empty), 32'd1);
    check_eq("ar_valid_mw", 32'(valid_mw), 32'd0);
    check_eq("ar_state", 32'(state_dbg), 32'(IDLE));
    drive_idle();
    step();
    reset = 1'b0;
    step();
    check_eq("ar_post_req", 32'(req_dmem), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
